lcm_from_gcd: RTL and testbench
===============================

Name: lcm_from_gcd

Overview:
- Downstream stage of the 8-bit binary GCD engine. Consumes operands M, N and the GCD they produced; computes LCM = (M / GCD) * N as a 2*WIDTH-bit result.
- Multi-cycle datapath: one restoring divider step per cycle, then one shift-add multiplier step per cycle. No hardware divider or multiplier array.
- Its start is driven by the GCD engine's TC, qualified by the system controller.

Parameters:
- WIDTH, 8, operand and GCD width; LCM is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- async_reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- M  input  WIDTH  operand 1 (dividend).
- N  input  WIDTH  operand 2 (multiplicand).
- GCD  input  WIDTH  GCD of M and N from the upstream engine.
- busy  output  1  high in every state except IDLE.
- done  output  1  single-cycle pulse when LCM/err are valid.
- err  output  1  invalid-input flag, valid with done, held until next start.
- LCM  output  2*WIDTH  result, valid with done, held until next start.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, err=0, LCM=0; all internal registers 0. Reset asserted mid-operation aborts immediately and produces no done.
- IDLE:
  - start=1 at an edge latches M, N, GCD and clears err/LCM.
  - Next state is DIV, or DONE if GCD==0; GCD==0 sets err=1 and LCM=0.
  - start=0 holds IDLE.
- DIV, WIDTH cycles:
  - Restoring division M/GCD, one quotient bit per cycle, MSB first.
  - Each cycle: partial remainder r = {r, next dividend bit}; if r >= GCD then r -= GCD and q bit = 1.
  - After WIDTH cycles, go to MUL.
  - If the final remainder != 0, set err=1 and LCM=0, and skip to DONE.
- MUL, WIDTH cycles:
  - Shift-add multiply of Q by N.
  - If the multiplier register (Q) LSB is 1, acc += multiplicand (N, zero-extended to 2*WIDTH).
  - Then shift the multiplier right and the multiplicand left.
  - After the last step go to DONE.
  - acc is 2*WIDTH bits and cannot overflow, since Q*N <= (2^WIDTH-1)^2.
- DONE, 1 cycle: done=1, LCM=acc (or 0 if err), then IDLE.
- Latency, with start high at edge 0:
  - Normal path: done is high after edge 2*WIDTH+1 (17 for WIDTH=8).
  - GCD==0: done after edge 1.
  - Non-zero remainder: done after edge WIDTH+1.
- start while busy is ignored, not queued. start high during the DONE cycle is also ignored; it must be held or re-presented in IDLE.
- M==0 or N==0 with GCD!=0 gives LCM=0, err=0. No special case is needed.
- M, N, GCD may change after the start edge without affecting the result.

Optional Feature:
- Macro LCM_EARLY_TERM_EN.
- Defined: MUL exits to DONE on the first cycle where the post-shift multiplier register is 0. It always spends at least 1 cycle in MUL. Normal-path latency becomes WIDTH + max(1, bitlen(Q)) + 1 edges.
- Undefined: MUL always runs exactly WIDTH cycles, giving a fixed latency of 2*WIDTH+1.
- Results and err are identical in both builds.

Test Plan:
- M=12, N=18, GCD=6, start pulse:
  - Q=2, LCM=36, err=0.
  - done after edge 17; with LCM_EARLY_TERM_EN, after edge 11.
- M=255, N=254, GCD=1 -> LCM=64770, err=0, done after edge 17 in both builds.
- M=12, N=18, GCD=0 -> done after edge 1, err=1, LCM=0, busy high for exactly 1 cycle.
- M=12, N=10, GCD=5 (remainder 2) -> done after edge 9, err=1, LCM=0.
- Busy-start and reset-mid behaviour:
  - Start M=12, N=18, GCD=6, then pulse start with M=8, N=8, GCD=8 at edge 5. The second request is ignored and the result is LCM=36.
  - Separately, assert async_reset between edges at edge 10. Outputs go to 0 immediately, there is no done pulse, and the block is in IDLE after release.
- M=0, N=200, GCD=200 -> LCM=0, err=0, done after edge 17 (after edge 10 with early termination, since Q=0).

Source files
------------

// File: rtl/lcm_from_gcd.sv
// lcm_from_gcd: LCM = (M / GCD) * N, computed serially downstream of the GCD engine.
// A restoring divider produces one quotient bit per cycle (MSB first). A shift-add
// multiplier then consumes one quotient bit per cycle.
// GCD == 0 or a non-zero division remainder flags err and forces LCM to 0.
// Optional build macro LCM_EARLY_TERM_EN: the multiply phase stops as soon as the
// remaining quotient bits are all zero. Results are unchanged; only latency shrinks.
//
// Handshake: start is sampled only in IDLE, and start in any other state is dropped,
// not queued. busy is high in every state except IDLE. done pulses for one cycle,
// and LCM/err are valid from that pulse until the next accepted start.
module lcm_from_gcd #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               async_reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   M,
    input  logic [WIDTH-1:0]   N,
    input  logic [WIDTH-1:0]   GCD,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [2*WIDTH-1:0] LCM,
    output logic [1:0]         state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;       // dividend shift register, MSB leaves first
    logic [WIDTH-1:0]   g_q, g_d;       // latched divisor
    logic [WIDTH-1:0]   r_q, r_d;       // partial remainder, always < divisor
    logic [WIDTH-1:0]   q_q, q_d;       // quotient during DIV, multiplier during MUL
    logic [2*WIDTH-1:0] n_q, n_d;       // multiplicand, shifts left during MUL
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [2*WIDTH-1:0] lcm_q, lcm_d;

    // One restoring-division step. If the shifted remainder is at least the divisor,
    // the true difference is below the divisor. So low-WIDTH-bit subtraction is exact.
    logic [WIDTH:0]     r_sh;
    logic               r_ge;
    logic [WIDTH-1:0]   r_next;
    logic [WIDTH-1:0]   q_shift;
    logic               mul_last;

    assign r_sh    = {r_q, m_q[WIDTH-1]};
    assign r_ge    = (r_sh >= {1'b0, g_q});
    assign r_next  = r_ge ? (r_sh[WIDTH-1:0] - g_q) : r_sh[WIDTH-1:0];
    assign q_shift = q_q >> 1;

`ifdef LCM_EARLY_TERM_EN
    assign mul_last = (cnt_q == LAST_STEP) || (q_shift == '0);
`else
    assign mul_last = (cnt_q == LAST_STEP);
`endif

    // Next-state and datapath update for the IDLE -> DIV -> MUL -> DONE sequence
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        g_d     = g_q;
        r_d     = r_q;
        q_d     = q_q;
        n_d     = n_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;
        lcm_d   = lcm_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d   = M;
                    g_d   = GCD;
                    n_d   = {{WIDTH{1'b0}}, N};
                    r_d   = '0;
                    q_d   = '0;
                    acc_d = '0;
                    cnt_d = '0;
                    lcm_d = '0;
                    err_d = (GCD == '0);
                    state_d = (GCD == '0) ? S_DONE : S_DIV;
                end
            end
            S_DIV: begin
                m_d   = m_q << 1;
                r_d   = r_next;
                q_d   = {q_q[WIDTH-2:0], r_ge};
                if (cnt_q == LAST_STEP) begin
                    cnt_d = '0;
                    if (r_next != '0) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_MUL;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_MUL: begin
                if (q_q[0]) acc_d = acc_q + n_q;
                q_d   = q_shift;
                n_d   = n_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (mul_last) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                lcm_d   = err_q ? '0 : acc_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any operation without a done pulse
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            g_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            n_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            lcm_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            g_q     <= g_d;
            r_q     <= r_d;
            q_q     <= q_d;
            n_q     <= n_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            lcm_q   <= lcm_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign LCM       = lcm_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_lcm_from_gcd.sv
// Bench for lcm_from_gcd: directed cases plus randomized operands, checked against
// an arithmetic reference (divide, modulo, multiply) with expected latency.
module tb_lcm_from_gcd;

    localparam int W = 8;

    logic           clk;
    logic           async_reset;
    logic           start;
    logic [W-1:0]   M, N, GCD;
    logic           busy, done, err;
    logic [2*W-1:0] LCM;
    logic [1:0]     state_dbg;

    int checks   = 0;
    int failures = 0;

    // expected {err, LCM} and expected done latency in edges after the start edge
    logic [2*W:0] exp_q[$];
    int           lat_q[$];

    lcm_from_gcd #(.WIDTH(W)) dut (
        .clk         (clk),
        .async_reset (async_reset),
        .start       (start),
        .M           (M),
        .N           (N),
        .GCD         (GCD),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .LCM         (LCM),
        .state_dbg   (state_dbg)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int bitlen(input int v);
        int b = 0;
        while (v > 0) begin
            b++;
            v = v >> 1;
        end
        return b;
    endfunction

    // reference: LCM = (M/GCD)*N with error cases, plus the edge count to done
    task automatic model_push(input int m, input int n, input int g);
        int q;
        int lat;
        if (g == 0) begin
            exp_q.push_back({1'b1, 16'd0});
            lat_q.push_back(1);
        end else if ((m % g) != 0) begin
            exp_q.push_back({1'b1, 16'd0});
            lat_q.push_back(W + 1);
        end else begin
            q = m / g;
            exp_q.push_back({1'b0, 16'(q * n)});
`ifdef LCM_EARLY_TERM_EN
            lat = W + ((bitlen(q) < 1) ? 1 : bitlen(q)) + 1;
`else
            lat = 2 * W + 1;
`endif
            lat_q.push_back(lat);
        end
    endtask

    // Drive one request; intf_edge > 0 presents a stray start before that edge,
    // intf_edge < 0 presents it during the DONE cycle. Called #1 after a rising edge.
    task automatic run_op(input int m, input int n, input int g, input int intf_edge);
        logic [2*W:0] exp;
        int           exp_lat;
        int           lat;
        int           intf;
        logic [2*W-1:0] held;
        model_push(m, n, g);
        exp     = exp_q.pop_front();
        exp_lat = lat_q.pop_front();
        intf    = (intf_edge < 0) ? exp_lat : intf_edge;
        M = W'(m); N = W'(n); GCD = W'(g); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        M = W'($urandom); N = W'($urandom); GCD = W'($urandom);
        check("busy_after_start", busy, 1);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == intf) begin
                start = 1'b1; M = 8'd8; N = 8'd8; GCD = 8'd8;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        check("done_latency", lat, exp_lat);
        check("err", err, exp[2*W]);
        check("lcm", LCM, exp[2*W-1:0]);
        check("busy_at_done", busy, 0);
        held = LCM;
        @(posedge clk); #1;
        check("done_pulse_width", done, 0);
        check("idle_after_done", busy, 0);
        check("lcm_held", LCM, exp[2*W-1:0]);
        check("err_held", err, exp[2*W]);
        if (held !== LCM) check("lcm_stable", LCM, held);
    endtask

    int m_r, n_r, g_r;
    int seen_done;

    initial begin
        // reset
        async_reset = 1'b1;
        start = 1'b0; M = '0; N = '0; GCD = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_lcm", LCM, 0);
        @(negedge clk);
        async_reset = 1'b0;
        @(posedge clk); #1;

        // directed cases
        run_op(12, 18, 6, 0);
        run_op(255, 254, 1, 0);
        run_op(12, 18, 0, 0);
        run_op(12, 10, 5, 0);
        run_op(0, 200, 200, 0);
        run_op(12, 18, 6, 5);     // stray start while busy
        run_op(12, 18, 6, -1);    // stray start during the DONE cycle
        run_op(5, 0, 5, 0);

        // reset mid-operation: asserted between edges 9 and 10
        M = 8'd12; N = 8'd18; GCD = 8'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        async_reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_lcm", LCM, 0);
        check("midrst_err", err, 0);
        check("midrst_done", done, 0);
        @(posedge clk);
        @(negedge clk);
        async_reset = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen_done = 1;
        end
        check("midrst_no_done", seen_done, 0);
        run_op(36, 7, 4, 0);

        // randomized operands
        for (int i = 0; i < 40; i++) begin
            g_r = $urandom_range(0, 20);
            if (i % 7 == 0) g_r = 0;
            if (g_r != 0 && $urandom_range(0, 2) != 0)
                m_r = g_r * $urandom_range(0, 255 / g_r);
            else
                m_r = $urandom_range(0, 255);
            n_r = $urandom_range(0, 255);
            if (i % 5 == 0) g_r = $urandom_range(1, 255);
            run_op(m_r, n_r, g_r, (i % 4 == 0) ? $urandom_range(2, 8) : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
